// File: rtl/tile_accumulator.sv
// Tile accumulator: bins an RGB pixel stream into an OUT_W x OUT_H grid of
// per-channel sums and pixel counts. Two banks of OUT_W entries ping-pong:
// one collects the current tile row while the other is streamed out through
// a valid/ready handshake. Column and row binning use running remainders
// instead of dividers.
module tile_accumulator #(
    parameter int MAX_WIDTH  = 1920,
    parameter int MAX_HEIGHT = 1080,
    parameter int OUT_W      = 16,
    parameter int OUT_H      = 8,
    parameter int COLOR_W    = 8,
    parameter int SUM_W      = 24,
    parameter int CNT_W      = 16
) (
    input  logic                          I_rgb_clk,
    input  logic                          I_rst,
    input  logic                          I_rgb_de,
    input  logic [COLOR_W-1:0]            I_rgb_r,
    input  logic [COLOR_W-1:0]            I_rgb_g,
    input  logic [COLOR_W-1:0]            I_rgb_b,
    input  logic                          I_new_row,
    input  logic                          I_new_frame,
    input  logic [$clog2(MAX_WIDTH)-1:0]  I_image_width,
    input  logic [$clog2(MAX_HEIGHT)-1:0] I_image_height,
    input  logic                          I_image_valid,
    output logic                          O_valid,
    input  logic                          I_ready,
    output logic [$clog2(OUT_W)-1:0]      O_tile_x,
    output logic [$clog2(OUT_H)-1:0]      O_tile_y,
    output logic [SUM_W-1:0]              O_sum_r,
    output logic [SUM_W-1:0]              O_sum_g,
    output logic [SUM_W-1:0]              O_sum_b,
    output logic [CNT_W-1:0]              O_count,
    output logic                          O_overflow,
    output logic                          O_frame_err
);

    localparam int WW   = $clog2(MAX_WIDTH);
    localparam int HW   = $clog2(MAX_HEIGHT);
    localparam int XW   = $clog2(OUT_W);
    localparam int YW   = $clog2(OUT_H);
    // One extra bit so remainder + step never wraps before the compare.
    localparam int CA_W = WW + 1;
    localparam int RA_W = HW + 1;
    // Entries 0..OUT_W-1 form bank 0, OUT_W..2*OUT_W-1 form bank 1.
    localparam int NE   = 2 * OUT_W;
    localparam int EW   = XW + 1;

    localparam logic [XW-1:0]   X_LAST   = XW'(OUT_W - 1);
    localparam logic [YW-1:0]   Y_LAST   = YW'(OUT_H - 1);
    localparam logic [CA_W-1:0] COL_STEP = CA_W'(OUT_W);
    localparam logic [RA_W-1:0] ROW_STEP = RA_W'(OUT_H);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Binning state
    logic [CA_W-1:0] col_acc_reg;
    logic [XW-1:0]   tile_x_reg;
    logic [RA_W-1:0] row_acc_reg;
    logic [YW-1:0]   tile_y_reg;
    logic            row_had_reg;

    // Emitter state
    logic            acc_bank_reg;
    logic [XW-1:0]   idx_reg;
    logic [YW-1:0]   emit_y_reg;
    logic            overflow_reg;
    logic            frame_err_reg;

    // Decoded events
    logic            pix_accept;
    logic            row_evt;
    logic            row_full;
    logic            row_done;
    logic            swap;
    logic            overflow_evt;
    logic            handshake;
    logic            emit_last;
    logic            frame_dirty;
    logic            clear_acc;
    logic [CA_W-1:0] col_sum;
    logic [RA_W-1:0] row_sum;
    logic [NE-1:0]   acc_nz;
    logic [EW-1:0]   rd_ent;

    // Flattened view of every entry, for the output read mux
    logic [SUM_W-1:0] ent_r [NE];
    logic [SUM_W-1:0] ent_g [NE];
    logic [SUM_W-1:0] ent_b [NE];
    logic [CNT_W-1:0] ent_c [NE];

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] sum,
                                                 input logic [COLOR_W-1:0] pix);
        logic [SUM_W:0] total;
        total = {1'b0, sum} + (SUM_W+1)'(pix);
        return total[SUM_W] ? '1 : total[SUM_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    // A pixel on a row/frame boundary cycle is deliberately dropped.
    assign pix_accept  = I_image_valid & I_rgb_de & ~I_new_row & ~I_new_frame;
    assign row_evt     = I_image_valid & I_new_row & ~I_new_frame;
    assign col_sum     = col_acc_reg + COL_STEP;
    assign row_sum     = row_acc_reg + ROW_STEP;
    assign row_full    = row_sum >= {1'b0, I_image_height};
    assign row_done    = row_evt & row_had_reg & row_full;
    assign emit_last   = (idx_reg == X_LAST);
    assign frame_dirty = |acc_nz;
    assign clear_acc   = overflow_evt | (I_new_frame & frame_dirty);

    // Emitter next-state and handshake decode
    always_comb begin
        state_next   = state_reg;
        O_valid      = 1'b0;
        swap         = 1'b0;
        overflow_evt = 1'b0;
        handshake    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (row_done) begin
                    swap       = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                O_valid      = 1'b1;
                handshake    = I_ready;
                overflow_evt = row_done;
                if (I_ready && emit_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Emitter state register
    always_ff @(posedge I_rgb_clk or posedge I_rst) begin
        if (I_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bank select, emit index, latched tile row and event pulses
    always_ff @(posedge I_rgb_clk or posedge I_rst) begin
        if (I_rst) begin
            acc_bank_reg  <= 1'b0;
            idx_reg       <= '0;
            emit_y_reg    <= '0;
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_evt;
            frame_err_reg <= I_new_frame & frame_dirty;
            if (swap) begin
                acc_bank_reg <= ~acc_bank_reg;
                emit_y_reg   <= tile_y_reg;
                idx_reg      <= '0;
            end else if (handshake) begin
                idx_reg <= emit_last ? '0 : idx_reg + XW'(1);
            end
        end
    end

    // Column/row remainder tracking; frame start overrides everything else
    always_ff @(posedge I_rgb_clk or posedge I_rst) begin
        if (I_rst) begin
            col_acc_reg <= '0;
            tile_x_reg  <= '0;
            row_acc_reg <= '0;
            tile_y_reg  <= '0;
            row_had_reg <= 1'b0;
        end else if (I_new_frame) begin
            col_acc_reg <= '0;
            tile_x_reg  <= '0;
            row_acc_reg <= '0;
            tile_y_reg  <= '0;
            row_had_reg <= 1'b0;
        end else if (row_evt) begin
            col_acc_reg <= '0;
            tile_x_reg  <= '0;
            row_had_reg <= 1'b0;
            // Empty lines (blanking) do not advance the vertical binning.
            if (row_had_reg) begin
                row_acc_reg <= row_full ? row_sum - {1'b0, I_image_height} : row_sum;
            end
            if (row_done) begin
                tile_y_reg <= (tile_y_reg == Y_LAST) ? '0 : tile_y_reg + YW'(1);
            end
        end else if (pix_accept) begin
            row_had_reg <= 1'b1;
            if (col_sum >= {1'b0, I_image_width}) begin
                col_acc_reg <= col_sum - {1'b0, I_image_width};
                if (tile_x_reg != X_LAST) begin
                    tile_x_reg <= tile_x_reg + XW'(1);
                end
            end else begin
                col_acc_reg <= col_sum;
            end
        end
    end

    // Per-entry storage. Kept in registers rather than RAM because a whole
    // bank must clear in one cycle on overflow or an aborted frame.
    genvar gi;
    generate
        for (gi = 0; gi < NE; gi++) begin : gen_entry
            localparam logic          BANK = (gi >= OUT_W);
            localparam logic [XW-1:0] COL  = XW'(gi % OUT_W);

            logic [SUM_W-1:0] sum_r_reg;
            logic [SUM_W-1:0] sum_g_reg;
            logic [SUM_W-1:0] sum_b_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             is_acc;
            logic             acc_hit;
            logic             emit_hit;

            assign is_acc   = (acc_bank_reg == BANK);
            assign acc_hit  = is_acc & pix_accept & (tile_x_reg == COL);
            assign emit_hit = ~is_acc & handshake & (idx_reg == COL);

            // Accumulate into the collecting bank; clear once emitted
            always_ff @(posedge I_rgb_clk or posedge I_rst) begin
                if (I_rst) begin
                    sum_r_reg <= '0;
                    sum_g_reg <= '0;
                    sum_b_reg <= '0;
                    cnt_reg   <= '0;
                end else if ((is_acc && clear_acc) || emit_hit) begin
                    sum_r_reg <= '0;
                    sum_g_reg <= '0;
                    sum_b_reg <= '0;
                    cnt_reg   <= '0;
                end else if (acc_hit) begin
                    sum_r_reg <= sat_add(sum_r_reg, I_rgb_r);
                    sum_g_reg <= sat_add(sum_g_reg, I_rgb_g);
                    sum_b_reg <= sat_add(sum_b_reg, I_rgb_b);
                    cnt_reg   <= sat_inc(cnt_reg);
                end
            end

            assign ent_r[gi]  = sum_r_reg;
            assign ent_g[gi]  = sum_g_reg;
            assign ent_b[gi]  = sum_b_reg;
            assign ent_c[gi]  = cnt_reg;
            assign acc_nz[gi] = is_acc & (|cnt_reg);
        end
    endgenerate

    // The emitting bank is always the one not collecting.
    assign rd_ent = acc_bank_reg ? EW'(idx_reg) : EW'(idx_reg) + EW'(OUT_W);

    assign O_tile_x    = O_valid ? idx_reg       : '0;
    assign O_tile_y    = O_valid ? emit_y_reg    : '0;
    assign O_sum_r     = O_valid ? ent_r[rd_ent] : '0;
    assign O_sum_g     = O_valid ? ent_g[rd_ent] : '0;
    assign O_sum_b     = O_valid ? ent_b[rd_ent] : '0;
    assign O_count     = O_valid ? ent_c[rd_ent] : '0;
    assign O_overflow  = overflow_reg;
    assign O_frame_err = frame_err_reg;

endmodule

// File: tb/tb_tile_accumulator.sv
// Directed bench for tile_accumulator: frames of known geometry are pushed in
// and every emitted tile is compared with hand-derived values.
`timescale 1ns/1ps
module tb_tile_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de = 1'b0;
    logic [7:0]  pr = '0;
    logic [7:0]  pg = '0;
    logic [7:0]  pb = '0;
    logic        new_row = 1'b0;
    logic        new_frame = 1'b0;
    logic [10:0] width = '0;
    logic [10:0] height = '0;
    logic        image_valid = 1'b0;
    logic        ready = 1'b0;
    logic        valid;
    logic [3:0]  tile_x;
    logic [2:0]  tile_y;
    logic [23:0] sum_r;
    logic [23:0] sum_g;
    logic [23:0] sum_b;
    logic [15:0] count;
    logic        overflow;
    logic        frame_err;

    always #5 clk = ~clk;

    tile_accumulator dut (
        .I_rgb_clk      (clk),
        .I_rst          (rst),
        .I_rgb_de       (de),
        .I_rgb_r        (pr),
        .I_rgb_g        (pg),
        .I_rgb_b        (pb),
        .I_new_row      (new_row),
        .I_new_frame    (new_frame),
        .I_image_width  (width),
        .I_image_height (height),
        .I_image_valid  (image_valid),
        .O_valid        (valid),
        .I_ready        (ready),
        .O_tile_x       (tile_x),
        .O_tile_y       (tile_y),
        .O_sum_r        (sum_r),
        .O_sum_g        (sum_g),
        .O_sum_b        (sum_b),
        .O_count        (count),
        .O_overflow     (overflow),
        .O_frame_err    (frame_err)
    );

    typedef struct {
        int x;
        int y;
        int r;
        int g;
        int b;
        int c;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   ovf_cnt = 0;
    int   ferr_cnt = 0;
    int   valid_cycles = 0;
    int   stall_viol = 0;
    bit   stall_prev = 1'b0;
    bit   ready_toggle = 1'b0;
    res_t held;

    // Observe outputs mid-cycle: record accepted tiles and check stall stability
    always @(negedge clk) begin
        res_t cur;
        cur.x = int'(tile_x);
        cur.y = int'(tile_y);
        cur.r = int'(sum_r);
        cur.g = int'(sum_g);
        cur.b = int'(sum_b);
        cur.c = int'(count);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (!valid || cur != held)) stall_viol++;
            if (overflow) ovf_cnt++;
            if (frame_err) ferr_cnt++;
            if (valid) valid_cycles++;
            if (valid && ready) begin
                q.push_back(cur);
                $display("tile x=%0d y=%0d cnt=%0d sum=(%0d,%0d,%0d)",
                         cur.x, cur.y, cur.c, cur.r, cur.g, cur.b);
            end
            stall_prev = valid && !ready;
            held = cur;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (ready_toggle) ready = ~ready;
    endtask

    // new_frame, nlines x (new_row cycle, pixels, gap), optional closing new_row
    task automatic send_frame(input int w, input int h, input int nlines,
                              input bit trailing, input bit ramp);
        width = 11'(w);
        height = 11'(h);
        new_frame = 1'b1;
        cyc();
        new_frame = 1'b0;
        for (int ln = 0; ln < nlines; ln++) begin
            new_row = 1'b1;
            cyc();
            new_row = 1'b0;
            for (int c = 0; c < w; c++) begin
                de = 1'b1;
                pr = ramp ? 8'(c) : 8'd10;
                pg = ramp ? 8'(c + 100) : 8'd20;
                pb = ramp ? 8'(255 - c) : 8'd30;
                cyc();
            end
            de = 1'b0;
            repeat (10) cyc();
        end
        if (trailing) begin
            new_row = 1'b1;
            cyc();
            new_row = 1'b0;
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            cyc();
            k++;
        end
        repeat (5) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        checks++;
        if (valid !== 1'b0 || tile_x !== 4'd0 || tile_y !== 3'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got valid=%0b x=%0d y=%0d, expected 0 0 0", valid, tile_x, tile_y);
        end
        checks++;
        if (sum_r !== 24'd0 || sum_g !== 24'd0 || sum_b !== 24'd0 || count !== 16'd0) begin
            fails++;
            $display("FAIL reset_data: got sum=(%0d,%0d,%0d) cnt=%0d, expected all 0", sum_r, sum_g, sum_b, count);
        end
        checks++;
        if (overflow !== 1'b0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_pulses: got ovf=%0b ferr=%0b, expected 0 0", overflow, frame_err);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_image_valid_gate();
        image_valid = 1'b0;
        ready = 1'b1;
        q.delete();
        valid_cycles = 0;
        send_frame(32, 16, 4, 1'b1, 1'b0);
        repeat (20) cyc();
        checks++;
        if (valid_cycles != 0 || q.size() != 0) begin
            fails++;
            $display("FAIL gate_no_output: got %0d valid cycles, expected 0", valid_cycles);
        end
        image_valid = 1'b1;
    endtask

    task automatic test_basic_frame();
        q.delete();
        ovf_cnt = 0;
        ferr_cnt = 0;
        ready = 1'b1;
        send_frame(32, 16, 16, 1'b1, 1'b0);
        wait_results(128, 300);
        checks++;
        if (q.size() != 128) begin
            fails++;
            $display("FAIL basic_count: got %0d tiles, expected 128", q.size());
        end
        for (int k = 0; k < q.size() && k < 128; k++) begin
            checks++;
            if (q[k].x != k % 16 || q[k].y != k / 16 || q[k].c != 4 ||
                q[k].r != 40 || q[k].g != 80 || q[k].b != 120) begin
                fails++;
                $display("FAIL basic_tile[%0d]: got x=%0d y=%0d cnt=%0d sum=(%0d,%0d,%0d), expected x=%0d y=%0d cnt=4 sum=(40,80,120)",
                         k, q[k].x, q[k].y, q[k].c, q[k].r, q[k].g, q[k].b, k % 16, k / 16);
            end
        end
        checks++;
        if (ovf_cnt != 0 || ferr_cnt != 0) begin
            fails++;
            $display("FAIL basic_pulses: got ovf=%0d ferr=%0d, expected 0 0", ovf_cnt, ferr_cnt);
        end
    endtask

    task automatic test_non_integer();
        int ecnt[16];
        int er[16];
        int eg[16];
        int eb[16];
        int ca = 0;
        int tx = 0;
        for (int i = 0; i < 16; i++) begin
            ecnt[i] = 0; er[i] = 0; eg[i] = 0; eb[i] = 0;
        end
        // Reference binning of one 40-pixel line into 16 columns
        for (int c = 0; c < 40; c++) begin
            ecnt[tx]++;
            er[tx] += c;
            eg[tx] += c + 100;
            eb[tx] += 255 - c;
            ca += 16;
            if (ca >= 40) begin
                ca -= 40;
                if (tx < 15) tx++;
            end
        end
        q.delete();
        ready = 1'b1;
        send_frame(40, 8, 8, 1'b1, 1'b1);
        wait_results(128, 200);
        checks++;
        if (q.size() != 128) begin
            fails++;
            $display("FAIL nonint_count: got %0d tiles, expected 128", q.size());
        end
        for (int k = 0; k < q.size() && k < 128; k++) begin
            checks++;
            if (q[k].x != k % 16 || q[k].y != k / 16 || q[k].c != ecnt[k % 16] ||
                q[k].r != er[k % 16] || q[k].g != eg[k % 16] || q[k].b != eb[k % 16] ||
                (q[k].c != 2 && q[k].c != 3)) begin
                fails++;
                $display("FAIL nonint_tile[%0d]: got x=%0d y=%0d cnt=%0d sum=(%0d,%0d,%0d), expected x=%0d y=%0d cnt=%0d sum=(%0d,%0d,%0d)",
                         k, q[k].x, q[k].y, q[k].c, q[k].r, q[k].g, q[k].b,
                         k % 16, k / 16, ecnt[k % 16], er[k % 16], eg[k % 16], eb[k % 16]);
            end
        end
        for (int row = 0; row < 8 && (row * 16 + 15) < q.size(); row++) begin
            int tot = 0;
            for (int i = 0; i < 16; i++) tot += q[row * 16 + i].c;
            checks++;
            if (tot != 40) begin
                fails++;
                $display("FAIL nonint_row_total[%0d]: got %0d pixels, expected 40", row, tot);
            end
        end
    endtask

    task automatic test_backpressure();
        q.delete();
        ovf_cnt = 0;
        stall_viol = 0;
        ready = 1'b1;
        ready_toggle = 1'b1;
        send_frame(32, 16, 16, 1'b1, 1'b0);
        wait_results(128, 400);
        ready_toggle = 1'b0;
        ready = 1'b1;
        repeat (5) cyc();
        checks++;
        if (q.size() != 128) begin
            fails++;
            $display("FAIL bp_count: got %0d tiles, expected 128", q.size());
        end
        for (int k = 0; k < q.size() && k < 128; k++) begin
            checks++;
            if (q[k].x != k % 16 || q[k].y != k / 16 || q[k].c != 4 || q[k].r != 40) begin
                fails++;
                $display("FAIL bp_tile[%0d]: got x=%0d y=%0d cnt=%0d r=%0d, expected x=%0d y=%0d cnt=4 r=40",
                         k, q[k].x, q[k].y, q[k].c, q[k].r, k % 16, k / 16);
            end
        end
        checks++;
        if (stall_viol != 0) begin
            fails++;
            $display("FAIL bp_stall_stable: got %0d unstable stall cycles, expected 0", stall_viol);
        end
        checks++;
        if (ovf_cnt != 0) begin
            fails++;
            $display("FAIL bp_overflow: got %0d pulses, expected 0", ovf_cnt);
        end
    endtask

    task automatic test_overflow();
        q.delete();
        ovf_cnt = 0;
        ready = 1'b0;
        send_frame(32, 16, 4, 1'b1, 1'b0);
        repeat (5) cyc();
        checks++;
        if (ovf_cnt != 1) begin
            fails++;
            $display("FAIL ovf_pulse: got %0d pulses, expected 1", ovf_cnt);
        end
        checks++;
        if (valid !== 1'b1 || tile_y !== 3'd0) begin
            fails++;
            $display("FAIL ovf_holding: got valid=%0b y=%0d, expected 1 0", valid, tile_y);
        end
        ready = 1'b1;
        wait_results(16, 60);
        checks++;
        if (q.size() != 16) begin
            fails++;
            $display("FAIL ovf_count: got %0d tiles, expected 16", q.size());
        end
        for (int k = 0; k < q.size() && k < 16; k++) begin
            checks++;
            if (q[k].x != k || q[k].y != 0 || q[k].c != 4 ||
                q[k].r != 40 || q[k].g != 80 || q[k].b != 120) begin
                fails++;
                $display("FAIL ovf_tile[%0d]: got x=%0d y=%0d cnt=%0d sum=(%0d,%0d,%0d), expected x=%0d y=0 cnt=4 sum=(40,80,120)",
                         k, q[k].x, q[k].y, q[k].c, q[k].r, q[k].g, q[k].b, k);
            end
        end
    endtask

    task automatic test_abort();
        q.delete();
        ferr_cnt = 0;
        ready = 1'b1;
        send_frame(32, 16, 5, 1'b0, 1'b0);
        send_frame(32, 16, 2, 1'b1, 1'b0);
        wait_results(48, 100);
        checks++;
        if (ferr_cnt != 1) begin
            fails++;
            $display("FAIL abort_frame_err: got %0d pulses, expected 1", ferr_cnt);
        end
        checks++;
        if (q.size() != 48) begin
            fails++;
            $display("FAIL abort_count: got %0d tiles, expected 48", q.size());
        end
        for (int k = 32; k < q.size() && k < 48; k++) begin
            checks++;
            if (q[k].x != k - 32 || q[k].y != 0 || q[k].c != 4 ||
                q[k].r != 40 || q[k].g != 80 || q[k].b != 120) begin
                fails++;
                $display("FAIL abort_next_tile[%0d]: got x=%0d y=%0d cnt=%0d sum=(%0d,%0d,%0d), expected x=%0d y=0 cnt=4 sum=(40,80,120)",
                         k, q[k].x, q[k].y, q[k].c, q[k].r, q[k].g, q[k].b, k - 32);
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        bit found = 1'b0;
        q.delete();
        ready = 1'b1;
        send_frame(32, 16, 2, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (valid === 1'b1 && tile_x === 4'd7) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL rst_emit_reach_idx7: got x=%0d valid=%0b, expected x=7 valid=1", tile_x, valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || tile_x !== 4'd0 || count !== 16'd0) begin
            fails++;
            $display("FAIL rst_emit_abort: got valid=%0b x=%0d cnt=%0d, expected 0 0 0", valid, tile_x, count);
        end
        repeat (2) cyc();
        rst = 1'b0;
        q.delete();
        valid_cycles = 0;
        repeat (30) cyc();
        checks++;
        if (valid_cycles != 0) begin
            fails++;
            $display("FAIL rst_emit_quiet: got %0d valid cycles, expected 0", valid_cycles);
        end
        // Two lines of a new frame; the completing new_row raises valid one cycle later
        send_frame(32, 16, 2, 1'b0, 1'b0);
        checks++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_emit_pre_valid: got %0b, expected 0", valid);
        end
        new_row = 1'b1;
        cyc();
        new_row = 1'b0;
        checks++;
        if (valid !== 1'b1 || tile_y !== 3'd0 || tile_x !== 4'd0 || count !== 16'd4 || sum_r !== 24'd40) begin
            fails++;
            $display("FAIL rst_emit_resume: got valid=%0b y=%0d x=%0d cnt=%0d r=%0d, expected 1 0 0 4 40",
                     valid, tile_y, tile_x, count, sum_r);
        end
        wait_results(16, 60);
        checks++;
        if (q.size() != 16) begin
            fails++;
            $display("FAIL rst_emit_count: got %0d tiles, expected 16", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_image_valid_gate();
        test_basic_frame();
        test_non_integer();
        test_backpressure();
        test_overflow();
        test_abort();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
